mips_cpu_sequencer: RTL and testbench
=====================================

Name: mips_cpu_sequencer

Overview:
- Multicycle control sequencer for the MIPS CPU core.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and stalls on the memory bus waitrequest.
- Holds the multiply/divide unit for a fixed latency and drives the 4-bit state bus consumed by the branch-decision unit.
- Owns branch-delay-slot sequencing: a taken branch redirects the PC only after the delay-slot instruction completes.

Parameters:
- MD_CYCLES, 32, total EXEC+MDWAIT cycles for mult/div (legal range 2..63).
- TIMEOUT, 1024, waitrequest watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26] from the IR
- fn  in  6  instruction[5:0] from the IR
- jump_in  in  1  branch/jump taken, from the branch-decision unit
- pc_zero  in  1  current PC == 0x00000000 (halt address)
- mem_waitrequest  in  1  bus stall
- state  out  4  current state encoding
- active  out  1  CPU running
- mem_read  out  1  bus read request
- mem_write  out  1  bus write request
- ir_write  out  1  load the IR from read data
- pc_write  out  1  update the PC this cycle
- pc_sel  out  1  0 = PC+4, 1 = latched branch target
- tgt_latch  out  1  capture the branch target register
- md_start  out  1  one-cycle start pulse to the mult/div unit
- timeout_err  out  1  watchdog tripped (held 0 when the feature is absent)

Behaviour:
- State encodings: FETCH=0000, DECODE=0001, EXEC=0010, MEM=0011, WB=0100, MDWAIT=0101, HALT=1111. State is registered.
- All other outputs are combinational from state, registered flags and inputs.
- Reset (async, rst_n low) values: state=FETCH, branch_pending=0, md counter=0, active=1, timeout_err=0. All strobes are 0 while in reset.
- Reset asserted mid-operation aborts immediately. No bus request survives reset.
- FETCH:
  - If pc_zero: go to HALT, with no mem_read.
  - Otherwise assert mem_read. Hold while mem_waitrequest=1.
  - On the first cycle with waitrequest=0: ir_write=1, next state DECODE.
- DECODE: one cycle, then EXEC.
- EXEC:
  - Class priority: load (opcode[5:3]=100) or store (opcode[5:3]=101) goes to MEM.
  - Else opcode=000000 with fn in 011000..011011: md_start=1, counter loaded with MD_CYCLES-2, go to MDWAIT.
  - Else go to WB.
  - Branch handling: if jump_in=1 and branch_pending=0, tgt_latch=1 and branch_pending is set at the clock edge.
  - jump_in while branch_pending=1 (branch in a delay slot) is ignored: no tgt_latch, and the pending target is kept.
- MEM:
  - Loads assert mem_read; stores assert mem_write.
  - The request is held stable while waitrequest=1.
  - When waitrequest=0, go to WB.
- MDWAIT: counter decrements each cycle. When the counter is 0, go to WB.
- WB (exactly one cycle, then FETCH): pc_write=1.
  - If branch_pending=1 and the instruction completing is not the branch that set it (tracked with a 1-bit slot flag): pc_sel=1, branch_pending cleared.
  - Otherwise pc_sel=0.
- HALT: terminal until reset. active=0, all strobes 0.
- Latency (zero wait states): ALU/branch 4 cycles, load/store 5 cycles, mult/div MD_CYCLES+3 cycles.
- The PC observes exactly one pc_write per instruction.
- mem_read and mem_write are never asserted together.

Optional Feature:
- Macro: MIPS_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit counter counts consecutive cycles with a request pending and waitrequest=1 in FETCH or MEM.
  - It clears on acceptance.
  - When the count reaches TIMEOUT: go to HALT, drop the request, and set timeout_err=1 (sticky until reset).
- Undefined: no counter, timeout_err tied to 0, and the CPU stalls indefinitely.

Decomposition:
- Package mips_cpu_pkg holds:
  - state_t enum with the encodings above; the branch-decision unit's EXEC compare must use state_t.EXEC.
  - Opcode/fn constants: OP_RTYPE, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU.
  - Load/store class masks.
- Natural sub-module: mips_cpu_bus_watchdog, which holds the timeout counter and is instantiated only under the macro.

Test Plan:
- Reset, then an ADDU-class instruction with zero waits:
  - state goes 0000, 0001, 0010, 0100, 0000.
  - ir_write and pc_write each pulse once.
  - pc_sel=0.
- FETCH with mem_waitrequest high for 3 cycles:
  - mem_read is held for 4 cycles.
  - ir_write fires only in the 4th cycle.
  - state is stuck at 0000 during the wait.
- BEQ taken (jump_in=1 in EXEC), then an ADDU:
  - tgt_latch pulses in the BEQ EXEC.
  - BEQ WB has pc_sel=0; the delay-slot WB has pc_sel=1.
  - branch_pending is 0 afterwards.
- DIV with MD_CYCLES=4:
  - md_start pulses in EXEC.
  - Exactly 3 MDWAIT cycles follow, then WB.
  - Total instruction length is 7 cycles.
- pc_zero=1 entering FETCH:
  - HALT (1111), active=0, no mem_read.
  - Stays there; rst_n low then high returns to FETCH with active=1.
- With MIPS_SEQ_TIMEOUT_EN and TIMEOUT=8, SW with waitrequest stuck at 1:
  - mem_write is held 8 cycles.
  - Then HALT, timeout_err=1, mem_write=0.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_pkg
// Shared types and constants for the MIPS multicycle control path.
//   state_t      : 4-bit sequencer state encoding, also decoded by the
//                  branch-decision unit (its EXEC compare uses state_t EXEC).
//   OP_/FN_      : opcode and function-field constants for mult/div.
//   LS_*         : load/store class mask and match values on opcode[5:0].
//   is_load / is_store / is_muldiv : instruction class helpers.
// ---------------------------------------------------------------------------
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'b0000,
        DECODE = 4'b0001,
        EXEC   = 4'b0010,
        MEM    = 4'b0011,
        WB     = 4'b0100,
        MDWAIT = 4'b0101,
        HALT   = 4'b1111
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // Loads are opcode 100xxx, stores 101xxx.
    localparam logic [5:0] LS_CLASS_MASK = 6'b111000;
    localparam logic [5:0] LOAD_MATCH    = 6'b100000;
    localparam logic [5:0] STORE_MATCH   = 6'b101000;

    function automatic logic is_load(input logic [5:0] op);
        return (op & LS_CLASS_MASK) == LOAD_MATCH;
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op & LS_CLASS_MASK) == STORE_MATCH;
    endfunction

    function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) &&
               ((fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU));
    endfunction

endpackage

// File: rtl/mips_cpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// mips_cpu_sequencer_if
// Memory-bus handshake between the control sequencer and the bus.
//   mem_read        : read request (instruction fetch or load)
//   mem_write       : write request (store)
//   mem_waitrequest : bus stall, request must be held while high
// Modports: master (sequencer side), slave (bus side).
// ---------------------------------------------------------------------------
interface mips_cpu_sequencer_if;
    logic mem_read;
    logic mem_write;
    logic mem_waitrequest;

    modport master (output mem_read, output mem_write, input mem_waitrequest);
    modport slave  (input mem_read, input mem_write, output mem_waitrequest);
endinterface

// File: rtl/mips_cpu_bus_watchdog.sv
// ---------------------------------------------------------------------------
// mips_cpu_bus_watchdog
// Counts consecutive stalled-request cycles and trips at TIMEOUT.
// Only instantiated when MIPS_SEQ_TIMEOUT_EN is defined.
//   clk, rst_n   : clock, async active-low reset
//   stall        : a request is pending and the bus holds waitrequest
//   trip         : this stalled cycle is the TIMEOUT-th in a row
//   timeout_err  : sticky flag, set on trip, cleared only by reset
// ---------------------------------------------------------------------------
module mips_cpu_bus_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic trip,
    output logic timeout_err
);

    logic [15:0] wait_cnt;

    // The counter holds the number of earlier stalled cycles, so the cycle
    // in which it equals TIMEOUT-1 is the one that brings it to TIMEOUT.
    assign trip = stall && (wait_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (trip) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b1;
        end else if (stall) begin
            wait_cnt <= wait_cnt + 16'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/mips_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// mips_cpu_sequencer
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB plus MDWAIT for the
// fixed-latency mult/div unit and a terminal HALT at PC 0. Taken branches
// redirect the PC at the WB of the following (delay-slot) instruction.
//
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   opcode, fn     : IR[31:26], IR[5:0]
//   jump_in        : branch/jump taken (sampled in EXEC)
//   pc_zero        : PC is the halt address
//   bus (master)   : mem_read / mem_write / mem_waitrequest
//   state          : current state encoding (state_t)
//   active         : CPU running (0 only in HALT)
//   ir_write, pc_write, pc_sel, tgt_latch, md_start : datapath strobes
//   timeout_err    : bus watchdog tripped
//
// Parameters: MD_CYCLES (EXEC+MDWAIT cycles for mult/div, 2..63),
//             TIMEOUT (watchdog limit, used only with the watchdog).
// Optional feature: define MIPS_SEQ_TIMEOUT_EN to enable the bus watchdog;
// without it timeout_err is tied low and stalls are unbounded.
// ---------------------------------------------------------------------------
module mips_cpu_sequencer
    import mips_cpu_pkg::*;
#(
    parameter int MD_CYCLES = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            fn,
    input  logic                  jump_in,
    input  logic                  pc_zero,
    mips_cpu_sequencer_if.master  bus,
    output logic [3:0]            state,
    output logic                  active,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_sel,
    output logic                  tgt_latch,
    output logic                  md_start,
    output logic                  timeout_err
);

    state_t     state_q, state_d;
    logic       branch_pending;  // a taken branch target is waiting to be applied
    logic       branch_slot;     // the instruction in flight is the one that set it
    logic       mem_is_store;    // MEM-phase direction, captured in EXEC
    logic [5:0] md_cnt;
    logic       mem_read_c, mem_write_c;
    logic       req_stall;
    logic       wd_trip;

    // A request is outstanding in FETCH (unless halting) and in MEM; derived
    // from state alone so the watchdog never loops through the strobe logic.
    assign req_stall = rst_n && bus.mem_waitrequest &&
                       (((state_q == FETCH) && !pc_zero) || (state_q == MEM));

`ifdef MIPS_SEQ_TIMEOUT_EN
    mips_cpu_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (req_stall),
        .trip        (wd_trip),
        .timeout_err (timeout_err)
    );
`else
    logic unused_timeout;
    assign unused_timeout = req_stall && (TIMEOUT != 0);
    assign wd_trip        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        active      = 1'b1;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        tgt_latch   = 1'b0;
        md_start    = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (pc_zero) begin
                    state_d = HALT;
                end else begin
                    mem_read_c = 1'b1;
                    if (wd_trip) begin
                        state_d = HALT;
                    end else if (!bus.mem_waitrequest) begin
                        ir_write = 1'b1;
                        state_d  = DECODE;
                    end
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                // A branch sitting in a delay slot must not overwrite the
                // target of the branch that is still pending.
                tgt_latch = jump_in && !branch_pending;
                if (is_load(opcode) || is_store(opcode)) begin
                    state_d = MEM;
                end else if (is_muldiv(opcode, fn)) begin
                    md_start = 1'b1;
                    state_d  = MDWAIT;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                mem_read_c  = !mem_is_store;
                mem_write_c = mem_is_store;
                if (wd_trip) begin
                    state_d = HALT;
                end else if (!bus.mem_waitrequest) begin
                    state_d = WB;
                end
            end
            MDWAIT: begin
                if (md_cnt == '0) begin
                    state_d = WB;
                end
            end
            WB: begin
                pc_write = 1'b1;
                pc_sel   = branch_pending && !branch_slot;
                state_d  = FETCH;
            end
            HALT: active = 1'b0;
            default: state_d = FETCH;
        endcase

        // Reset silences every strobe immediately, even before the state
        // register has been observed by downstream logic.
        if (!rst_n) begin
            mem_read_c  = 1'b0;
            mem_write_c = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_sel      = 1'b0;
            tgt_latch   = 1'b0;
            md_start    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= FETCH;
            branch_pending <= 1'b0;
            branch_slot    <= 1'b0;
            mem_is_store   <= 1'b0;
            md_cnt         <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == EXEC) begin
                mem_is_store <= is_store(opcode);
                if (tgt_latch) begin
                    branch_pending <= 1'b1;
                    branch_slot    <= 1'b1;
                end
            end
            if (md_start) begin
                // EXEC is the first of MD_CYCLES; MDWAIT runs while the
                // counter walks down to zero inclusive.
                md_cnt <= 6'(MD_CYCLES - 2);
            end else if ((state_q == MDWAIT) && (md_cnt != '0)) begin
                md_cnt <= md_cnt - 6'd1;
            end
            if (state_q == WB) begin
                branch_slot <= 1'b0;
                if (pc_sel) begin
                    branch_pending <= 1'b0;
                end
            end
        end
    end

    assign state         = state_q;
    assign bus.mem_read  = mem_read_c;
    assign bus.mem_write = mem_write_c;

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_sequencer
// Self-checking bench for mips_cpu_sequencer (MD_CYCLES=4, TIMEOUT=8).
// Instruction vectors are expanded into a per-cycle queue of expected
// outputs plus the bus/branch inputs for that cycle; the queue is drained
// one clock at a time and compared. Hand-written sequences cover reset,
// abort mid-access, HALT and (with MIPS_SEQ_TIMEOUT_EN) the watchdog.
// ---------------------------------------------------------------------------
module tb_mips_cpu_sequencer;

    localparam int MDC = 4;

    localparam logic [3:0] S_FETCH  = 4'b0000;
    localparam logic [3:0] S_DECODE = 4'b0001;
    localparam logic [3:0] S_EXEC   = 4'b0010;
    localparam logic [3:0] S_MEM    = 4'b0011;
    localparam logic [3:0] S_WB     = 4'b0100;
    localparam logic [3:0] S_MDWAIT = 4'b0101;
    localparam logic [3:0] S_HALT   = 4'b1111;

    typedef struct packed {
        logic [3:0] state;
        logic       active;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_sel;
        logic       tgt_latch;
        logic       md_start;
        logic       timeout_err;
    } obs_t;

    typedef struct {
        logic wr;   // mem_waitrequest this cycle
        logic jmp;  // jump_in this cycle
        obs_t exp;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       jmp;
        int         fw;   // fetch wait cycles
        int         mw;   // memory wait cycles
        int         len;  // expected FETCH..WB length in cycles
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, fn;
    logic       jump_in, pc_zero;
    logic [3:0] state;
    logic       active, ir_write, pc_write, pc_sel, tgt_latch, md_start, timeout_err;

    mips_cpu_sequencer_if bus();

    mips_cpu_sequencer #(.MD_CYCLES(MDC), .TIMEOUT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .fn          (fn),
        .jump_in     (jump_in),
        .pc_zero     (pc_zero),
        .bus         (bus),
        .state       (state),
        .active      (active),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_sel      (pc_sel),
        .tgt_latch   (tgt_latch),
        .md_start    (md_start),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic m_pending = 1'b0;  // model: a taken branch awaits its delay slot
    cyc_t sb[$];
    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic obs_t exp_obs(input logic [3:0] st);
        obs_t o;
        o        = '0;
        o.state  = st;
        o.active = (st != S_HALT);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.state       = state;
        o.active      = active;
        o.mem_read    = bus.mem_read;
        o.mem_write   = bus.mem_write;
        o.ir_write    = ir_write;
        o.pc_write    = pc_write;
        o.pc_sel      = pc_sel;
        o.tgt_latch   = tgt_latch;
        o.md_start    = md_start;
        o.timeout_err = timeout_err;
        return o;
    endfunction

    function automatic cyc_t mk(input logic [3:0] st);
        cyc_t c;
        c.wr  = 1'b0;
        c.jmp = 1'b0;
        c.exp = exp_obs(st);
        return c;
    endfunction

    // Expand one instruction into its expected cycle-by-cycle behaviour.
    task automatic push_instr(input vec_t v);
        cyc_t c;
        logic ld, st, md, tgt;
        ld  = (v.op[5:3] == 3'b100);
        st  = (v.op[5:3] == 3'b101);
        md  = !ld && !st && (v.op == 6'd0) && (v.fn >= 6'd24) && (v.fn <= 6'd27);
        tgt = v.jmp && !m_pending;
        for (int i = 0; i <= v.fw; i++) begin
            c = mk(S_FETCH);
            c.wr = (i < v.fw);
            c.exp.mem_read = 1'b1;
            c.exp.ir_write = (i == v.fw);
            sb.push_back(c);
        end
        sb.push_back(mk(S_DECODE));
        c = mk(S_EXEC);
        c.jmp = v.jmp;
        c.exp.tgt_latch = tgt;
        c.exp.md_start  = md;
        sb.push_back(c);
        if (ld || st) begin
            for (int i = 0; i <= v.mw; i++) begin
                c = mk(S_MEM);
                c.wr = (i < v.mw);
                c.exp.mem_read  = ld;
                c.exp.mem_write = st;
                sb.push_back(c);
            end
        end
        if (md) begin
            for (int i = 0; i < MDC - 1; i++) sb.push_back(mk(S_MDWAIT));
        end
        c = mk(S_WB);
        c.exp.pc_write = 1'b1;
        c.exp.pc_sel   = m_pending;
        sb.push_back(c);
        m_pending = tgt;
    endtask

    // Starts at a negedge-aligned FETCH cycle, ends after the WB sample.
    task automatic run_vec(input int idx, input vec_t v);
        cyc_t c;
        obs_t act;
        int   n, len;
        n   = 0;
        len = 0;
        push_instr(v);
        while (sb.size() > 0) begin
            c = sb.pop_front();
            @(negedge clk);
            if (n == 0) begin
                opcode = v.op;
                fn     = v.fn;
            end
            bus.mem_waitrequest = c.wr;
            jump_in             = c.jmp;
            #1;
            act = sample();
            check($sformatf("v%0d cyc%0d", idx, n), 32'(act), 32'(c.exp));
            if (act.pc_write && len == 0) len = n + 1;
            n++;
        end
        check($sformatf("v%0d latency", idx), len, v.len);
        jump_in = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        m_pending = 1'b0;
    endtask

    initial begin
        //           op         fn         jmp fw mw len
        vecs[0]  = '{6'b000000, 6'b100001, 0, 0, 0, 4};  // ADDU
        vecs[1]  = '{6'b000000, 6'b100001, 0, 3, 0, 7};  // ADDU, 3 fetch waits
        vecs[2]  = '{6'b000100, 6'b000000, 1, 0, 0, 4};  // BEQ taken
        vecs[3]  = '{6'b000000, 6'b100001, 0, 0, 0, 4};  // delay slot -> redirect
        vecs[4]  = '{6'b000000, 6'b011010, 0, 0, 0, 7};  // DIV
        vecs[5]  = '{6'b100011, 6'b000000, 0, 0, 0, 5};  // LW
        vecs[6]  = '{6'b101011, 6'b000000, 0, 0, 2, 7};  // SW, 2 mem waits
        vecs[7]  = '{6'b000000, 6'b011001, 0, 0, 0, 7};  // MULTU
        vecs[8]  = '{6'b000100, 6'b000000, 1, 0, 0, 4};  // BEQ taken
        vecs[9]  = '{6'b000101, 6'b000000, 1, 0, 0, 4};  // BNE in slot: ignored
        vecs[10] = '{6'b100011, 6'b000000, 0, 1, 1, 7};  // LW, waits both phases
        vecs[11] = '{6'b000010, 6'b000000, 1, 0, 0, 4};  // J
        vecs[12] = '{6'b101011, 6'b000000, 0, 0, 0, 5};  // SW in slot
        vecs[13] = '{6'b000000, 6'b011000, 0, 0, 0, 7};  // MULT
        vecs[14] = '{6'b000000, 6'b011011, 0, 0, 0, 7};  // DIVU
        vecs[15] = '{6'b000000, 6'b011100, 0, 0, 0, 4};  // fn just above mult/div
        vecs[16] = '{6'b000100, 6'b000000, 1, 0, 0, 4};  // BEQ taken
        vecs[17] = '{6'b000000, 6'b011010, 0, 0, 0, 7};  // DIV in slot
        vecs[18] = '{6'b100000, 6'b000000, 0, 0, 0, 5};  // LB after redirect

        rst_n = 1'b0;
        opcode = '0;
        fn = '0;
        jump_in = 1'b0;
        pc_zero = 1'b0;
        bus.mem_waitrequest = 1'b0;

        // Reset state, with no bus request despite sitting in FETCH.
        repeat (2) @(negedge clk);
        #1 check("reset state", 32'(sample()), 32'(exp_obs(S_FETCH)));
        release_reset();

        for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

        // Reset mid-way through a stalled load aborts the request at once.
        @(negedge clk);
        opcode = 6'b100011;
        bus.mem_waitrequest = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.mem_waitrequest = 1'b1;
        #1 check("abort pre mem_read", 32'(bus.mem_read), 32'd1);
        #1 rst_n = 1'b0;
        #1 check("abort in reset", 32'(sample()), 32'(exp_obs(S_FETCH)));
        bus.mem_waitrequest = 1'b0;
        release_reset();
        run_vec(100, vecs[0]);

        // Halt at PC 0: no fetch, terminal until reset.
        @(negedge clk);
        pc_zero = 1'b1;
        #1 check("halt entry fetch", 32'(sample()), 32'(exp_obs(S_FETCH)));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check($sformatf("halt hold%0d", i), 32'(sample()), 32'(exp_obs(S_HALT)));
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("halt reset", 32'(sample()), 32'(exp_obs(S_FETCH)));
        pc_zero = 1'b0;
        release_reset();
        #1 check("halt resume", 32'({bus.mem_read, active, state}), 32'({1'b1, 1'b1, S_FETCH}));
        run_vec(101, vecs[0]);

`ifdef MIPS_SEQ_TIMEOUT_EN
        begin
            obs_t e;
            @(negedge clk);
            opcode = 6'b101011;
            bus.mem_waitrequest = 1'b0;
            @(negedge clk);
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                bus.mem_waitrequest = 1'b1;
                e = exp_obs(S_MEM);
                e.mem_write = 1'b1;
                #1 check($sformatf("wd write%0d", i), 32'(sample()), 32'(e));
            end
            e = exp_obs(S_HALT);
            e.timeout_err = 1'b1;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                #1 check($sformatf("wd halt%0d", i), 32'(sample()), 32'(e));
            end
            @(negedge clk);
            rst_n = 1'b0;
            bus.mem_waitrequest = 1'b0;
            #1 check("wd reset", 32'(sample()), 32'(exp_obs(S_FETCH)));
            release_reset();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
